// File: rtl/fetch_stage_pkg.sv
// Shared fetch-pipeline definitions: fetch FSM states, reset PC and PC step.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        S_REQ,
        S_HOLD,
        S_DRAIN
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// Hold register for an instruction stalled in fetch, plus the per-slot
// misaligned-redirect flag when FETCH_MISALIGN_EN is defined.
module fetch_hold_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] din,
    output logic [31:0] dout
`ifdef FETCH_MISALIGN_EN
    ,
    input  logic        flag_load,
    input  logic        flag_in,
    output logic        flag
`endif
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            dout <= '0;
        else if (load)
            dout <= din;
    end

`ifdef FETCH_MISALIGN_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            flag <= 1'b0;
        else if (flag_load)
            flag <= flag_in;
    end
`endif

endmodule

// File: rtl/flopenr.sv
// Enabled flop with asynchronous active-low reset to a parameterised value.
module flopenr #(
    parameter int unsigned         WIDTH     = 32,
    parameter logic [WIDTH-1:0]    RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q <= RESET_VAL;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem handshake and presents
// RDD/PCF/PCPlus4F to decode. Optional feature macro: FETCH_MISALIGN_EN.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        RedirectF,
    input  logic [31:0] RedirectPCF,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] RDD,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        InstrValidF,
    output logic        MisalignF
);

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next, redir_pc, target, hold_data;
    logic         pc_en, hold_load, redir_en, valid, consume;

    assign target = align_word(RedirectPCF);

    flopenr #(.WIDTH(32), .RESET_VAL(RESET_PC)) u_pc (
        .clk (clk),
        .rst (rst),
        .en  (pc_en),
        .d   (pc_next),
        .q   (pc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_REQ;
            redir_pc <= '0;
        end else begin
            state <= state_next;
            if (redir_en)
                redir_pc <= target;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc + PC_STEP;
        pc_en      = 1'b0;
        hold_load  = 1'b0;
        redir_en   = 1'b0;
        valid      = 1'b0;
        consume    = 1'b0;
        case (state)
            S_REQ: begin
                if (imem_ack) begin
                    if (RedirectF) begin
                        pc_next = target;
                        pc_en   = 1'b1;
                    end else begin
                        valid = 1'b1;
                        if (!StallF) begin
                            pc_en   = 1'b1;
                            consume = 1'b1;
                        end else begin
                            hold_load  = 1'b1;
                            state_next = S_HOLD;
                        end
                    end
                end else if (RedirectF) begin
                    redir_en   = 1'b1;
                    state_next = S_DRAIN;
                end
            end
            S_HOLD: begin
                valid = 1'b1;
                if (RedirectF) begin
                    pc_next    = target;
                    pc_en      = 1'b1;
                    state_next = S_REQ;
                end else if (!StallF) begin
                    pc_en      = 1'b1;
                    consume    = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_DRAIN: begin
                redir_en = RedirectF;
                // A redirect landing on the drain ack wins over the latched target.
                if (imem_ack) begin
                    pc_next    = RedirectF ? target : redir_pc;
                    pc_en      = 1'b1;
                    state_next = S_REQ;
                end
            end
            default: state_next = S_REQ;
        endcase
    end

    assign imem_req    = rst && (state != S_HOLD);
    assign imem_addr   = pc;
    assign InstrValidF = rst && valid;
    assign RDD         = (state == S_HOLD) ? hold_data : imem_rdata;
    assign PCF         = pc;
    assign PCPlus4F    = pc + PC_STEP;

`ifdef FETCH_MISALIGN_EN
    logic mis_flag;

    fetch_hold_buf u_hold (
        .clk       (clk),
        .rst       (rst),
        .load      (hold_load),
        .din       (imem_rdata),
        .dout      (hold_data),
        .flag_load (RedirectF || consume),
        .flag_in   (RedirectF && (RedirectPCF[1:0] != 2'b00)),
        .flag      (mis_flag)
    );

    assign MisalignF = mis_flag && InstrValidF;
`else
    fetch_hold_buf u_hold (
        .clk  (clk),
        .rst  (rst),
        .load (hold_load),
        .din  (imem_rdata),
        .dout (hold_data)
    );

    assign MisalignF = 1'b0;
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the combined ARM/RISC-V pipeline: the producer side of the fetch→decode interface. It owns the program counter and issues word requests to instruction memory over a request/acknowledge handshake. It presents each fetched instruction to the decode stage on `RDD`, together with `PCF` and `PCPlus4F`. It also absorbs decode stalls, memory wait states and control-flow redirects without losing or duplicating an instruction.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `StallF`  in  1  hazard unit: decode will not capture this cycle; hold the presented instruction.
- `RedirectF`  in  1  redirect request (taken branch / PC write) this cycle.
- `RedirectPCF`  in  32  redirect target.
- `imem_req`  out  1  instruction-memory request.
- `imem_addr`  out  32  word address of the request, always 4-byte aligned.
- `imem_ack`  in  1  memory completes the request; `imem_rdata` is valid this cycle.
- `imem_rdata`  in  32  instruction word.
- `RDD`  out  32  instruction presented to decode.
- `PCF`  out  32  PC of `RDD`.
- `PCPlus4F`  out  32  `PCF + 4`; decode uses it as ARM r15 (PC+8 of the decode instruction).
- `InstrValidF`  out  1  `RDD` holds a real instruction; when 0 the hazard unit flushes decode (bubble).
- `MisalignF`  out  1  presented slot came from a misaligned redirect (see Configuration).

## Operation
- States: `S_REQ` (request outstanding), `S_HOLD` (instruction latched, decode stalled), `S_DRAIN` (discarding a stale in-flight response).
- `imem_req` = 1 in `S_REQ` and `S_DRAIN`. `imem_addr` = PC register in `S_REQ`, and the address of the stale request in `S_DRAIN`.
- Memory rule: once raised, `imem_req`/`imem_addr` stay stable until `imem_ack`. Acknowledge latency is 0..N cycles.
- `S_REQ`, no ack: `InstrValidF`=0. If `RedirectF`, latch the target into `redir_pc` and go to `S_DRAIN`.
- `S_REQ`, ack, `RedirectF`: drop the data, PC ← target, stay in `S_REQ`. Redirect has priority over stall.
- `S_REQ`, ack, no redirect, `~StallF`: `RDD` = `imem_rdata` (combinational pass), `InstrValidF`=1, PC ← PC+4, stay.
- `S_REQ`, ack, no redirect, `StallF`: latch `imem_rdata` into the hold register, go to `S_HOLD`. `InstrValidF`=1 this cycle.
- `S_HOLD`: `RDD` = hold register, `InstrValidF`=1, PC unchanged.
  - `RedirectF`: drop the hold, PC ← target, go to `S_REQ`.
  - `~StallF`: PC ← PC+4, go to `S_REQ`.
- `S_DRAIN`: `InstrValidF`=0. On ack, discard the data, PC ← `redir_pc`, go to `S_REQ`. A newer `RedirectF` in `S_DRAIN` overwrites `redir_pc`.
- Redirect target low bits: `RedirectPCF[1:0]` are always cleared before loading the PC.
- PC arithmetic: 32-bit, wraps modulo 2^32; PC 32'hFFFF_FFFC advances to 0.

## Timing
- Reset (asynchronous, active-low): state `S_REQ`, PC = `RESET_PC`, hold = 0, `redir_pc` = 0, `InstrValidF`=0, `MisalignF`=0.
- `imem_req`=0 while reset is asserted. `imem_req`=1 from the first cycle after release.
- Zero-wait memory: one instruction per cycle. Latency from PC-register update to `RDD` valid is 0 cycles (same cycle as ack).
- Redirect: the first instruction from the target is presented no earlier than the cycle after `RedirectF`. With zero-wait memory, exactly the next cycle.
- Reset mid-wait: the outstanding request is abandoned. Memory must tolerate a deasserted `imem_req` during reset.
- `StallF` with `InstrValidF`=0 has no effect.

## Configuration
- `FETCH_MISALIGN_EN` defined:
  - A redirect with `RedirectPCF[1:0]` ≠ 0 sets a per-slot flag.
  - `MisalignF`=1 accompanies the first instruction presented from that target (held through `S_HOLD`). The flag clears when that slot is consumed or on the next redirect.
- Macro undefined: low bits are silently cleared, `MisalignF` is tied to 0, and no flag register is instantiated.

## Structure
- Shared pipeline package holds:
  - the state enum `fetch_state_t` (`S_REQ`, `S_HOLD`, `S_DRAIN`);
  - `RESET_PC_DEFAULT`;
  - the `PC_STEP` = 4 constant.
- One sub-module, `fetch_hold_buf`: the 32-bit hold register plus its `MisalignF` flag, with load/clear controls.
- PC register uses the codebase's enabled resettable flop.

## Test plan
- Reset release, zero-wait memory returning `addr^32'hA5A5_0000`:
  - `imem_addr` = 0, 4, 8 on consecutive cycles.
  - `RDD` matches each address; `PCPlus4F` = `PCF`+4.
- Ack delayed 3 cycles at PC 0x10:
  - `InstrValidF`=0 for 3 cycles, then `RDD` = word(0x10).
  - `imem_addr` stays 0x10 throughout.
- `StallF`=1 for 2 cycles on the ack of 0x20:
  - `RDD` = word(0x20) held for 3 cycles.
  - Next request is 0x24, and 0x20 is not re-requested.
- `RedirectF` to 0x100 while a 0x30 request waits 2 more cycles:
  - Data for 0x30 is discarded.
  - Next request is 0x100; no instruction from 0x30 is ever valid.
- Redirect to 0x102 with `FETCH_MISALIGN_EN`:
  - Fetch from 0x100 with `MisalignF`=1 on that slot only.
  - Without the macro, `MisalignF` stays 0.
- Redirect to 0xFFFF_FFFC: next fetches are 0xFFFF_FFFC, then 0x0000_0000.
